display_sprites_regs: RTL and testbench
=======================================

DISPLAY_SPRITES_REGS -- requirements
Module: display_sprites_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width; legal values are 32 and 64.
REQ-002 SHALL have parameter NUM_REGS, default 8, register count; legal values are powers of 2 from 4 to 64.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte-address width; it must be at least clog2(NUM_REGS*DW/8).
REQ-004 SHALL have parameter SHADOW_EN, default 1: 1 means regs_o updates only on vsync; 0 means regs_o tracks the live registers.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- S_AXI_ACLK, in, 1: the single clock.
- S_AXI_ARESETN, in, 1: reset, asynchronous, active-low.
- S_AXI_AWADDR, in, AW; S_AXI_AWPROT, in, 3 (ignored); S_AXI_AWVALID, in, 1; S_AXI_AWREADY, out, 1.
- S_AXI_WDATA, in, DW; S_AXI_WSTRB, in, DW/8; S_AXI_WVALID, in, 1; S_AXI_WREADY, out, 1.
- S_AXI_BRESP, out, 2; S_AXI_BVALID, out, 1; S_AXI_BREADY, in, 1.
- S_AXI_ARADDR, in, AW; S_AXI_ARPROT, in, 3 (ignored); S_AXI_ARVALID, in, 1; S_AXI_ARREADY, out, 1.
- S_AXI_RDATA, out, DW; S_AXI_RRESP, out, 2; S_AXI_RVALID, out, 1; S_AXI_RREADY, in, 1.
- vsync_i, in, 1: frame sync, synchronous to S_AXI_ACLK.
- regs_o, out, NUM_REGS*DW: display copy of the registers; register k occupies bits [k*DW +: DW].
- shadow_pending_o, out, 1: a live register has been written since the last shadow update.

Function
REQ-006 SHALL decode register index = addr[clog2(DW/8) +: clog2(NUM_REGS)]; low byte-offset bits are ignored.
REQ-007 SHALL treat any address >= NUM_REGS*DW/8 as out of range: a write is dropped with BRESP=2'b10 (SLVERR); a read returns RDATA=0 with RRESP=2'b10.
REQ-008 SHALL implement the write FSM with states W_IDLE, W_HAVE_A, W_HAVE_D and W_RESP:
- AW and W are accepted independently, each into a one-entry holding register.
- AWREADY=1 only in W_IDLE and W_HAVE_D; WREADY=1 only in W_IDLE and W_HAVE_A.
REQ-009 SHALL commit the write on the clock edge at which both address and data are held (or both handshake in the same cycle), then enter W_RESP with BVALID=1 from the next cycle.
REQ-010 SHALL update only the byte lanes whose WSTRB bit is 1; WSTRB=0 leaves the register unchanged but still returns OKAY.
REQ-011 SHALL hold BVALID and BRESP stable until BREADY; on the BVALID&BREADY edge the FSM returns to W_IDLE; back-to-back write throughput is one write per 2 cycles.
REQ-012 SHALL implement the read FSM with states R_IDLE and R_DATA:
- ARREADY=1 only in R_IDLE.
- On the AR handshake, RDATA and RRESP are registered from the live register and RVALID=1 from the next cycle.
- RDATA and RRESP are held until RREADY, then the FSM returns to R_IDLE.
REQ-013 SHALL, when a read handshake and a write commit to the same register occur on the same edge, return the pre-write value.
REQ-014 SHALL run the read and write channels concurrently with no mutual stalling.
REQ-015 SHALL, with SHADOW_EN=1, detect a vsync_i rising edge (vsync_i=1 and the previous-cycle sample =0) and copy all live registers to regs_o on that edge; shadow_pending_o clears on the same edge.
REQ-016 SHALL set shadow_pending_o on any committed in-range write with a non-zero WSTRB.
REQ-017 SHALL, when a write commit coincides with a vsync rising edge, copy the pre-write value to regs_o and leave shadow_pending_o=1.
REQ-018 SHALL, with SHADOW_EN=0, update regs_o on the write-commit edge and tie shadow_pending_o to 0.
REQ-019 SHALL ignore a held vsync_i level; only one update occurs per rising edge.

Reset
REQ-020 SHALL, while S_AXI_ARESETN=0 (asynchronously), clear every live register, regs_o and shadow_pending_o, and set the vsync sample to 0.
REQ-021 SHALL, during reset, force both FSMs to their idle states and drive AWREADY, WREADY, ARREADY, BVALID and RVALID to 0, with RDATA, BRESP and RRESP = 0.
REQ-022 SHALL assert the READY outputs from the first edge after reset deassertion.
REQ-023 SHALL, on reset mid-transaction, discard the transaction and never issue its response.

Verification
REQ-024 SHALL cover: write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, all RRESP and BRESP = OKAY.
REQ-025 SHALL cover: write 0xAABBCCDD to reg 1, then write 0x11223344 to reg 1 with WSTRB=4'b0101 -> readback 0xAA22CC44.
REQ-026 SHALL cover: W presented 3 cycles before AW, then a write to 0x100 with NUM_REGS=8 -> the first write completes correctly; the second returns BRESP=SLVERR and all registers are unchanged.
REQ-027 SHALL cover (SHADOW_EN=1): write 0x5 to reg 0 -> regs_o[31:0] stays 0 and shadow_pending_o=1; a vsync_i rising edge -> regs_o[31:0]=0x5 and shadow_pending_o=0.
REQ-028 SHALL cover: a write to reg 2 commits on the same edge as a vsync rising edge, with a read of reg 2 handshaking on that edge -> regs_o keeps the old value, RDATA returns the old value, shadow_pending_o=1.
REQ-029 SHALL cover: S_AXI_ARESETN driven low while BVALID=1 and BREADY=0 -> BVALID=0 immediately; all registers and regs_o read 0 after reset.

Source files
------------

// File: rtl/display_sprites_regs.sv
// display_sprites_regs: AXI4-Lite register bank with a vsync-latched display copy
module display_sprites_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter bit SHADOW_EN = 1
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  input  logic                                   vsync_i,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic                                   shadow_pending_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int LOG_BW = $clog2(SW);
  localparam int LOG_N = $clog2(NUM_REGS);
  localparam int LOG_BYTES = LOG_BW + LOG_N;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [AW-1:0] awaddr_q, awaddr_d, c_addr;
  logic [DW-1:0] wdata_q, wdata_d, c_data, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d, c_strb;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];
  logic [DW-1:0] shadow_q [NUM_REGS];
  logic [DW-1:0] shadow_d [NUM_REGS];
  logic vsync_q, pending_q, pending_d;
  logic aw_hs, w_hs, ar_hs, commit, wr_en, c_oor, r_oor, vsync_rise;
  logic [LOG_N-1:0] c_idx, r_idx;
  logic unused;
  // Write and read channel FSMs; the commit uses held halves where one side arrived earlier
  always_comb begin
    aw_hs = S_AXI_AWVALID & awready_q;
    w_hs = S_AXI_WVALID & wready_q;
    c_addr = (w_state_q == W_HAVE_A) ? awaddr_q : S_AXI_AWADDR;
    c_data = (w_state_q == W_HAVE_D) ? wdata_q : S_AXI_WDATA;
    c_strb = (w_state_q == W_HAVE_D) ? wstrb_q : S_AXI_WSTRB;
    c_idx = c_addr[LOG_BW +: LOG_N];
    c_oor = (c_addr >> LOG_BYTES) != '0;
    commit = (w_state_q == W_IDLE && aw_hs && w_hs) || (w_state_q == W_HAVE_A && w_hs) ||
             (w_state_q == W_HAVE_D && aw_hs);
    wr_en = commit & ~c_oor;
    awaddr_d = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wdata_d = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d = w_hs ? S_AXI_WSTRB : wstrb_q;
    w_state_d = commit ? W_RESP :
                (w_state_q == W_IDLE && aw_hs) ? W_HAVE_A :
                (w_state_q == W_IDLE && w_hs) ? W_HAVE_D :
                (w_state_q == W_RESP && S_AXI_BREADY) ? W_IDLE : w_state_q;
    awready_d = w_state_d == W_IDLE || w_state_d == W_HAVE_D;
    wready_d = w_state_d == W_IDLE || w_state_d == W_HAVE_A;
    bvalid_d = w_state_d == W_RESP;
    bresp_d = commit ? (c_oor ? 2'b10 : 2'b00) : bresp_q;
    ar_hs = S_AXI_ARVALID & arready_q;
    r_idx = S_AXI_ARADDR[LOG_BW +: LOG_N];
    r_oor = (S_AXI_ARADDR >> LOG_BYTES) != '0;
    r_state_d = ar_hs ? R_DATA : (r_state_q == R_DATA && S_AXI_RREADY) ? R_IDLE : r_state_q;
    arready_d = r_state_d == R_IDLE;
    rvalid_d = r_state_d == R_DATA;
    rdata_d = ar_hs ? (r_oor ? '0 : regs_q[r_idx]) : rdata_q;
    rresp_d = ar_hs ? (r_oor ? 2'b10 : 2'b00) : rresp_q;
  end
  // Byte-lane register update and shadow capture; the shadow takes the pre-write value
  always_comb begin
    vsync_rise = vsync_i & ~vsync_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      for (int b = 0; b < SW; b++)
        if (wr_en && c_idx == LOG_N'(k) && c_strb[b]) regs_d[k][b*8 +: 8] = c_data[b*8 +: 8];
      shadow_d[k] = vsync_rise ? regs_q[k] : shadow_q[k];
      regs_o[k*DW +: DW] = SHADOW_EN ? shadow_q[k] : regs_q[k];
    end
    pending_d = (wr_en && |c_strb) ? 1'b1 : vsync_rise ? 1'b0 : pending_q;
  end
  // State, holding registers, registered handshake outputs and register storage
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      regs_q <= '{default: '0};
      shadow_q <= '{default: '0};
      vsync_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      regs_q <= regs_d;
      shadow_q <= shadow_d;
      vsync_q <= vsync_i;
      pending_q <= pending_d;
    end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY = wready_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign shadow_pending_o = SHADOW_EN ? pending_q : 1'b0;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, c_addr, S_AXI_ARADDR};
endmodule

// File: tb/tb_display_sprites_regs.sv
// tb_display_sprites_regs: scoreboard bench with a behavioural register/shadow model
module tb_display_sprites_regs;
  localparam int DW = 32;
  localparam int N = 8;
  localparam int AW = 12;
  logic clk = 0, rst_n = 0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, vsync = 0;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, pend;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [N*DW-1:0] regs_o;

  always #5 clk = ~clk;

  display_sprites_regs #(.C_S_AXI_DATA_WIDTH(DW), .NUM_REGS(N), .C_S_AXI_ADDR_WIDTH(AW), .SHADOW_EN(1)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .vsync_i(vsync), .regs_o(regs_o), .shadow_pending_o(pend)
  );

  logic [DW-1:0] m_regs [N];
  logic [DW-1:0] m_shadow [N];
  logic m_pend;
  logic [1:0] bq [$];
  logic [DW+1:0] rq [$];
  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit oor(input logic [AW-1:0] a);
    return int'(a) >= N * DW / 8;
  endfunction

  function automatic logic [N*DW-1:0] flat_shadow();
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = m_shadow[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_regs[k] = '0;
      m_shadow[k] = '0;
    end
    m_pend = 0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    if (!oor(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_regs[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
      if (s != 0) m_pend = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected responses whenever a B or R handshake is about to happen
  always @(negedge clk) if (rst_n) begin
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_unexpected: got bresp %0h expected none", bresp);
      end else check("bresp", bresp, bq.pop_front());
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL r_unexpected: got rdata %0h expected none", rdata);
      end else begin
        logic [DW+1:0] e;
        e = rq.pop_front();
        check("rdata", rdata, e[DW+1:2]);
        check("rresp", rresp, e[1:0]);
      end
    end
  end

  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                             input int aw_at, input int w_at);
    bit aw_done = 0, w_done = 0, fa, fw;
    int c = 0;
    bq.push_back(oor(a) ? 2'b10 : 2'b00);
    model_write(a, d, s);
    awaddr = a;
    wdata = d;
    wstrb = s;
    while (!(aw_done && w_done) && c < 64) begin
      if (c == aw_at) awvalid = 1;
      if (c == w_at) wvalid = 1;
      fa = awvalid && awready;
      fw = wvalid && wready;
      tick();
      c++;
      if (fa) begin awvalid = 0; aw_done = 1; end
      if (fw) begin wvalid = 0; w_done = 1; end
    end
    check("aw_w_accept", {aw_done, w_done}, 2'b11);
  endtask

  task automatic finish_b(input int dly);
    repeat (dly) tick();
    bready = 1;
    for (int c = 0; c < 32 && !bvalid; c++) tick();
    check("bvalid_wait", bvalid, 1'b1);
    if (bvalid) tick();
    bready = 0;
  endtask

  task automatic issue_read(input logic [AW-1:0] a);
    bit acc = 0, f;
    rq.push_back({oor(a) ? '0 : m_regs[a[4:2]], oor(a) ? 2'b10 : 2'b00});
    araddr = a;
    arvalid = 1;
    for (int c = 0; c < 32 && !acc; c++) begin
      f = arvalid && arready;
      tick();
      if (f) begin arvalid = 0; acc = 1; end
    end
    check("ar_accept", acc, 1'b1);
  endtask

  task automatic finish_r(input int dly);
    repeat (dly) tick();
    rready = 1;
    for (int c = 0; c < 32 && !rvalid; c++) tick();
    check("rvalid_wait", rvalid, 1'b1);
    if (rvalid) tick();
    rready = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    issue_write(a, d, s, 0, 0);
    finish_b(0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    issue_read(a);
    finish_r(0);
  endtask

  task automatic check_display();
    check("regs_o", regs_o, flat_shadow());
    check("shadow_pending", pend, m_pend);
  endtask

  task automatic vsync_pulse();
    vsync = 1;
    tick();
    for (int k = 0; k < N; k++) m_shadow[k] = m_regs[k];
    m_pend = 0;
    vsync = 0;
    tick();
    check_display();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("awready_rst", awready, 1'b0);
    check("wready_rst", wready, 1'b0);
    check("arready_rst", arready, 1'b0);
    check("bvalid_rst", {bvalid, bresp}, 3'b0);
    check("rvalid_rst", {rvalid, rresp, rdata}, '0);
    check_display();
    rst_n = 1;
    tick();
    check("readies_after_rst", {awready, wready, arready}, 3'b111);
    // Shadow holds old display value until vsync
    wr(12'h000, 32'h5, 4'hf);
    check_display();
    vsync_pulse();
    // Basic write then readback of four registers
    for (int i = 0; i < 4; i++) wr(AW'(i * 4), DW'(i + 1), 4'hf);
    for (int i = 0; i < 4; i++) rd(AW'(i * 4));
    check_display();
    // Partial-strobe merge
    wr(12'h004, 32'hAABBCCDD, 4'hf);
    wr(12'h004, 32'h11223344, 4'b0101);
    rd(12'h004);
    vsync_pulse();
    // W ahead of AW, then an out-of-range write and a zero-strobe write
    issue_write(12'h010, 32'hDEADBEEF, 4'hf, 3, 0);
    finish_b(1);
    vsync_pulse();
    wr(12'h100, 32'hCAFEF00D, 4'hf);
    wr(12'h014, 32'h12345678, 4'h0);
    check_display();
    for (int i = 0; i < N; i++) rd(AW'(i * 4));
    rd(12'h100);
    rd(12'h01B);
    // A held vsync level triggers only once
    vsync = 1;
    tick();
    for (int k = 0; k < N; k++) m_shadow[k] = m_regs[k];
    m_pend = 0;
    wr(12'h00C, 32'h0BADC0DE, 4'hf);
    repeat (3) tick();
    check_display();
    vsync = 0;
    tick();
    vsync_pulse();
    // Write commit, read handshake and vsync rise on one edge
    wr(12'h008, 32'h22220000, 4'hf);
    vsync_pulse();
    check("idle_readies", {awready, wready, arready}, 3'b111);
    rq.push_back({m_regs[2], 2'b00});
    bq.push_back(2'b00);
    awaddr = 12'h008;
    wdata = 32'h99;
    wstrb = 4'hf;
    araddr = 12'h008;
    {awvalid, wvalid, arvalid, vsync} = 4'b1111;
    tick();
    for (int k = 0; k < N; k++) m_shadow[k] = m_regs[k];
    m_pend = 0;
    model_write(12'h008, 32'h99, 4'hf);
    {awvalid, wvalid, arvalid, vsync} = 4'b0000;
    check_display();
    finish_b(0);
    finish_r(0);
    rd(12'h008);
    // Randomised mix of writes, reads and frame syncs
    for (int it = 0; it < 60; it++) begin
      int op;
      logic [AW-1:0] a;
      op = int'($urandom_range(0, 3));
      a = AW'($urandom_range(0, 'h4f));
      if (op < 2) begin
        issue_write(a, DW'($urandom), 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        finish_b(int'($urandom_range(0, 2)));
      end else if (op == 2) begin
        issue_read(a);
        finish_r(int'($urandom_range(0, 2)));
      end else vsync_pulse();
    end
    check_display();
    // Reset while a write response is stalled
    issue_write(12'h000, 32'h77, 4'hf, 0, 0);
    for (int c = 0; c < 8 && !bvalid; c++) tick();
    check("bvalid_before_rst", bvalid, 1'b1);
    #2;
    rst_n = 0;
    #1;
    check("bvalid_in_rst", bvalid, 1'b0);
    check("readies_in_rst", {awready, wready, arready}, 3'b000);
    bq.delete();
    model_reset();
    check_display();
    repeat (2) tick();
    rst_n = 1;
    tick();
    check("readies_after_rst2", {awready, wready, arready}, 3'b111);
    check("bvalid_after_rst2", bvalid, 1'b0);
    check_display();
    for (int i = 0; i < N; i++) rd(AW'(i * 4));
    check("bq_empty", bq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
